hci_mem_bank_responder: RTL and testbench

- Memory-side responder for the word-interleaved HWPE bank protocol: it terminates NB_BANKS hci_mem-style channels, one per bank, and serves them from an internal array of 32-bit word banks.
- Produces grant, read-valid and read data exactly as a TCDM bank does, including a deterministic, parameterised grant-stall pattern that exercises the initiator's stall path.
- Used as the far end of the HWPE interconnect in block-level benches and small FPGA configurations; also exports access statistics.

---
 rtl/hci_mem_bank_responder_pkg.sv | 24 ++
 rtl/hci_mem_bank_responder_if.sv | 33 +++
 rtl/hci_mem_bank_responder_bank_model.sv | 106 ++++++++++
 rtl/hci_mem_bank_responder.sv | 108 ++++++++++
 tb/tb_hci_mem_bank_responder.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hci_mem_bank_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hci_mem_responder_pkg
// Description : Shared widths and the per-bank request bundle for the
//               hci_mem bank responder.
// Revision    : 1.0 - initial release
// ============================================================================
package hci_mem_responder_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;
    localparam int ADD_W  = 32;

    // Address is carried at full width; each bank picks its own word index.
    typedef struct packed {
        logic              req;
        logic              wen;
        logic [ADD_W-1:0]  add;
        logic [BE_W-1:0]   be;
        logic [WORD_W-1:0] data;
    } hci_mem_req_t;

endpackage
`default_nettype wire

// File: rtl/hci_mem_bank_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : hci_mem_bank_responder_if
// Description : NB_BANKS hci_mem channels, one per bank, with initiator
//               (master) and memory (slave) views.
// Revision    : 1.0 - initial release
// ============================================================================
interface hci_mem_bank_responder_if
    import hci_mem_responder_pkg::*;
#(
    parameter int NB_BANKS = 8,
    parameter int AWM      = 12
);
    logic [NB_BANKS-1:0]             req;
    logic [NB_BANKS-1:0]             gnt;
    logic [NB_BANKS-1:0]             wen;
    logic [NB_BANKS-1:0][AWM+1:0]    add;
    logic [NB_BANKS-1:0][BE_W-1:0]   be;
    logic [NB_BANKS-1:0][WORD_W-1:0] data;
    logic [NB_BANKS-1:0]             r_valid;
    logic [NB_BANKS-1:0][WORD_W-1:0] r_data;

    modport master (
        output req, wen, add, be, data,
        input  gnt, r_valid, r_data
    );

    modport slave (
        input  req, wen, add, be, data,
        output gnt, r_valid, r_data
    );
endinterface
`default_nettype wire

// File: rtl/hci_mem_bank_responder_bank_model.sv
`default_nettype none
// ============================================================================
// Module      : hci_mem_bank_model
// Description : One TCDM-like bank: storage, grant-stall counter, 1-cycle
//               read response, and per-cycle access event strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module hci_mem_bank_model
    import hci_mem_responder_pkg::*;
#(
    parameter int AWM          = 12,
    parameter int STALL_PERIOD = 0
) (
    input  wire logic          i_clk,
    input  wire logic          i_rst_n,
    input  wire logic          i_clear,
    input  wire hci_mem_req_t  i_req,
    output logic               o_gnt,
    output logic               o_r_valid,
    output logic [WORD_W-1:0]  o_r_data,
    output logic               o_rd_ev,
    output logic               o_wr_ev,
    output logic               o_stall_ev
);

    localparam int c_depth = 2 ** AWM;

    logic [WORD_W-1:0] r_mem [c_depth];
    logic              r_rvalid;
    logic [WORD_W-1:0] r_rdata;
    logic [AWM-1:0]    w_idx;
    logic              w_stall;
    logic              w_rd;
    logic              w_wr;
    logic              unused_add;

    assign w_idx      = i_req.add[AWM+1:2];
    assign unused_add = ^{i_req.add[1:0], i_req.add[ADD_W-1:AWM+2]};

    generate
        if (STALL_PERIOD == 0) begin : g_no_stall
            assign w_stall = 1'b0;
        end else begin : g_stall
            localparam int c_sc_w = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
            localparam logic [c_sc_w-1:0] c_last = c_sc_w'(STALL_PERIOD - 1);

            logic [c_sc_w-1:0] r_stall_cnt;

            // Counter only moves on requesting cycles, so the deny lands on
            // every STALL_PERIOD-th attempt regardless of idle gaps.
            assign w_stall = (r_stall_cnt == c_last);

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_stall_cnt <= '0;
                end else if (i_clear) begin
                    r_stall_cnt <= '0;
                end else if (i_req.req) begin
                    r_stall_cnt <= w_stall ? '0 : r_stall_cnt + c_sc_w'(1);
                end
            end
        end
    endgenerate

    assign o_gnt      = i_req.req & ~w_stall;
    assign w_rd       = i_req.req & ~w_stall &  i_req.wen;
    assign w_wr       = i_req.req & ~w_stall & ~i_req.wen;
    assign o_rd_ev    = w_rd;
    assign o_wr_ev    = w_wr;
    assign o_stall_ev = i_req.req & w_stall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr && !i_clear) begin
            for (int k = 0; k < BE_W; k++) begin
                if (i_req.be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= i_req.data[8*k +: 8];
                end
            end
        end
    end

    // Read data is sticky: it only changes on the next accepted read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (i_clear) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= r_mem[w_idx];
            end
        end
    end

    assign o_r_valid = r_rvalid;
    assign o_r_data  = r_rdata;

endmodule
`default_nettype wire

// File: rtl/hci_mem_bank_responder.sv
`default_nettype none
// ============================================================================
// Module      : hci_mem_bank_responder
// Description : Memory-side responder for NB_BANKS word-interleaved hci_mem
//               channels, with saturating access statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module hci_mem_bank_responder
    import hci_mem_responder_pkg::*;
#(
    parameter int NB_BANKS     = 8,
    parameter int AWM          = 12,
    parameter int STALL_PERIOD = 0,
    parameter int CNT_W        = 32
) (
    input  wire logic               clk_i,
    input  wire logic               rst_ni,
    input  wire logic               clear_i,
    hci_mem_bank_responder_if.slave bus,
    output logic [CNT_W-1:0]        rd_cnt_o,
    output logic [CNT_W-1:0]        wr_cnt_o,
    output logic [CNT_W-1:0]        stall_cnt_o
);

    localparam int c_pop_w = $clog2(NB_BANKS + 1);
    localparam int c_sum_w = CNT_W + c_pop_w;

    logic [NB_BANKS-1:0] w_rd_ev;
    logic [NB_BANKS-1:0] w_wr_ev;
    logic [NB_BANKS-1:0] w_st_ev;
    logic [CNT_W-1:0]    r_rd_cnt;
    logic [CNT_W-1:0]    r_wr_cnt;
    logic [CNT_W-1:0]    r_st_cnt;

    generate
        for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
            hci_mem_req_t      w_req;
            logic              w_gnt;
            logic              w_rvalid;
            logic [WORD_W-1:0] w_rdata;

            assign w_req.req  = bus.req[b];
            assign w_req.wen  = bus.wen[b];
            assign w_req.add  = ADD_W'(bus.add[b]);
            assign w_req.be   = bus.be[b];
            assign w_req.data = bus.data[b];

            hci_mem_bank_model #(
                .AWM          (AWM),
                .STALL_PERIOD (STALL_PERIOD)
            ) u_bank (
                .i_clk      (clk_i),
                .i_rst_n    (rst_ni),
                .i_clear    (clear_i),
                .i_req      (w_req),
                .o_gnt      (w_gnt),
                .o_r_valid  (w_rvalid),
                .o_r_data   (w_rdata),
                .o_rd_ev    (w_rd_ev[b]),
                .o_wr_ev    (w_wr_ev[b]),
                .o_stall_ev (w_st_ev[b])
            );

            assign bus.gnt[b]     = w_gnt;
            assign bus.r_valid[b] = w_rvalid;
            assign bus.r_data[b]  = w_rdata;
        end
    endgenerate

    function automatic logic [c_pop_w-1:0] f_popcount(input logic [NB_BANKS-1:0] v);
        logic [c_pop_w-1:0] n;
        n = '0;
        for (int i = 0; i < NB_BANKS; i++) begin
            n = n + c_pop_w'(v[i]);
        end
        return n;
    endfunction

    // Widened add so any carry out of CNT_W pins the counter at all-ones.
    function automatic logic [CNT_W-1:0] f_sat_add(input logic [CNT_W-1:0]   a,
                                                   input logic [c_pop_w-1:0] inc);
        logic [c_sum_w-1:0] s;
        s = c_sum_w'(a) + c_sum_w'(inc);
        return (s[c_sum_w-1:CNT_W] != '0) ? '1 : s[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_st_cnt <= '0;
        end else if (clear_i) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
            r_st_cnt <= '0;
        end else begin
            r_rd_cnt <= f_sat_add(r_rd_cnt, f_popcount(w_rd_ev));
            r_wr_cnt <= f_sat_add(r_wr_cnt, f_popcount(w_wr_ev));
            r_st_cnt <= f_sat_add(r_st_cnt, f_popcount(w_st_ev));
        end
    end

    assign rd_cnt_o    = r_rd_cnt;
    assign wr_cnt_o    = r_wr_cnt;
    assign stall_cnt_o = r_st_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hci_mem_bank_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_hci_mem_bank_responder
// Description : Self-checking bench: directed plan items plus randomized
//               traffic against a word-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hci_mem_bank_responder;
    import hci_mem_responder_pkg::*;

    localparam int NB  = 8;
    localparam int AWA = 12;
    localparam int AWS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    hci_mem_bank_responder_if #(.NB_BANKS(NB), .AWM(AWA)) bus_a ();
    hci_mem_bank_responder_if #(.NB_BANKS(NB), .AWM(AWS)) bus_s ();
    hci_mem_bank_responder_if #(.NB_BANKS(NB), .AWM(AWS)) bus_c ();

    logic [31:0] rd_a, wr_a, st_a, rd_s, wr_s, st_s;
    logic [3:0]  rd_c, wr_c, st_c;

    hci_mem_bank_responder #(.NB_BANKS(NB), .AWM(AWA), .STALL_PERIOD(0), .CNT_W(32)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .bus(bus_a),
        .rd_cnt_o(rd_a), .wr_cnt_o(wr_a), .stall_cnt_o(st_a));

    hci_mem_bank_responder #(.NB_BANKS(NB), .AWM(AWS), .STALL_PERIOD(3), .CNT_W(32)) dut_s (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(1'b0), .bus(bus_s),
        .rd_cnt_o(rd_s), .wr_cnt_o(wr_s), .stall_cnt_o(st_s));

    hci_mem_bank_responder #(.NB_BANKS(NB), .AWM(AWS), .STALL_PERIOD(0), .CNT_W(4)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(1'b0), .bus(bus_c),
        .rd_cnt_o(rd_c), .wr_cnt_o(wr_c), .stall_cnt_o(st_c));

    int checks = 0;
    int errors = 0;

    // Reference model for dut_a: flat word map keyed by bank*depth + index.
    logic [31:0]   m_mem [int];
    logic [NB-1:0] m_rv;
    logic [31:0]   m_rd [NB];
    longint        m_rdc, m_wrc, m_stc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_word(input int key);
        return m_mem.exists(key) ? m_mem[key] : 32'h0;
    endfunction

    task automatic model_reset();
        m_mem.delete();
        m_rv  = '0;
        for (int b = 0; b < NB; b++) m_rd[b] = '0;
        m_rdc = 0;
        m_wrc = 0;
        m_stc = 0;
    endtask

    task automatic idle_all();
        bus_a.req = '0; bus_a.wen = '0; bus_a.add = '0; bus_a.be = '0; bus_a.data = '0;
        bus_s.req = '0; bus_s.wen = '0; bus_s.add = '0; bus_s.be = '0; bus_s.data = '0;
        bus_c.req = '0; bus_c.wen = '0; bus_c.add = '0; bus_c.be = '0; bus_c.data = '0;
    endtask

    task automatic set_a(input int b, input logic rd, input logic [13:0] add,
                         input logic [3:0] be, input logic [31:0] data);
        bus_a.req[b]  = 1'b1;
        bus_a.wen[b]  = rd;
        bus_a.add[b]  = add;
        bus_a.be[b]   = be;
        bus_a.data[b] = data;
    endtask

    // Called at posedge+1 with inputs driven; returns at the next posedge+1.
    task automatic tick_a();
        int          key;
        logic [31:0] w;
        #1;
        chk("gnt_a", {56'h0, bus_a.gnt}, {56'h0, bus_a.req});
        m_rv = '0;
        if (clear) begin
            for (int b = 0; b < NB; b++) m_rd[b] = '0;
            m_rdc = 0;
            m_wrc = 0;
            m_stc = 0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (bus_a.req[b]) begin
                    key = b * (2 ** AWA) + int'(bus_a.add[b][AWA+1:2]);
                    if (bus_a.wen[b]) begin
                        m_rv[b] = 1'b1;
                        m_rd[b] = m_word(key);
                        m_rdc++;
                    end else begin
                        w = m_word(key);
                        for (int k = 0; k < 4; k++)
                            if (bus_a.be[b][k]) w[8*k +: 8] = bus_a.data[b][8*k +: 8];
                        m_mem[key] = w;
                        m_wrc++;
                    end
                end
            end
        end
        @(posedge clk); #1;
        chk("r_valid_a", {56'h0, bus_a.r_valid}, {56'h0, m_rv});
        for (int b = 0; b < NB; b++)
            chk($sformatf("r_data_a[%0d]", b), {32'h0, bus_a.r_data[b]}, {32'h0, m_rd[b]});
        chk("rd_cnt_a", {32'h0, rd_a}, m_rdc);
        chk("wr_cnt_a", {32'h0, wr_a}, m_wrc);
        chk("stall_cnt_a", {32'h0, st_a}, m_stc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic exp_g;
        int   nresp;

        idle_all();
        model_reset();
        bus_a.req = 8'h5A;
        bus_a.wen = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_gnt", {56'h0, bus_a.gnt}, 64'h5A);
        chk("reset_rvalid", {56'h0, bus_a.r_valid}, 64'h0);
        chk("reset_rdata0", {32'h0, bus_a.r_data[0]}, 64'h0);
        chk("reset_rdcnt", {32'h0, rd_a}, 64'h0);
        chk("reset_wrcnt", {32'h0, wr_a}, 64'h0);
        chk("reset_s_rvalid", {56'h0, bus_s.r_valid}, 64'h0);
        idle_all();
        rst_n = 1'b1;

        // Write then read back on bank 3.
        set_a(3, 1'b0, 14'h010, 4'hF, 32'hDEADBEEF);
        tick_a();
        idle_all();
        set_a(3, 1'b1, 14'h010, 4'h0, 32'h0);
        tick_a();
        chk("plan_rvalid3", {63'h0, bus_a.r_valid[3]}, 64'h1);
        chk("plan_rdata3", {32'h0, bus_a.r_data[3]}, 64'hDEADBEEF);
        chk("plan_rdcnt", {32'h0, rd_a}, 64'd1);
        chk("plan_wrcnt", {32'h0, wr_a}, 64'd1);

        // Partial byte-enable write.
        idle_all();
        set_a(5, 1'b0, 14'h020, 4'hF, 32'hAAAAAAAA);
        tick_a();
        idle_all();
        set_a(5, 1'b0, 14'h020, 4'b0101, 32'h11223344);
        tick_a();
        idle_all();
        set_a(5, 1'b1, 14'h020, 4'h0, 32'h0);
        tick_a();
        chk("plan_be_merge", {32'h0, bus_a.r_data[5]}, 64'hAA22AA44);

        // All banks read every cycle for 10 cycles.
        for (int c = 0; c < 10; c++) begin
            idle_all();
            for (int b = 0; b < NB; b++) set_a(b, 1'b1, 14'((b + c) * 4), 4'h0, 32'h0);
            tick_a();
            chk("plan_all_rvalid", {56'h0, bus_a.r_valid}, 64'hFF);
        end
        idle_all();
        tick_a();
        chk("plan_rdcnt82", {32'h0, rd_a}, 64'd82);
        chk("plan_idle_rvalid", {56'h0, bus_a.r_valid}, 64'h0);

        // Randomized traffic with occasional clears (reads only in clear cycles).
        for (int c = 0; c < 200; c++) begin
            idle_all();
            clear = ($urandom_range(0, 24) == 0);
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, 3) != 0)
                    set_a(b, clear ? 1'b1 : 1'($urandom_range(0, 1)),
                          {12'($urandom_range(0, 15)), 2'($urandom_range(0, 3))},
                          4'($urandom_range(0, 15)), $urandom);
            end
            tick_a();
        end
        clear = 1'b0;

        // Read issued together with clear: no response, not counted, memory kept.
        idle_all();
        set_a(2, 1'b0, 14'h01C, 4'hF, 32'h0BADF00D);
        tick_a();
        idle_all();
        set_a(2, 1'b1, 14'h01C, 4'h0, 32'h0);
        clear = 1'b1;
        tick_a();
        clear = 1'b0;
        chk("clr_rvalid", {63'h0, bus_a.r_valid[2]}, 64'h0);
        chk("clr_rdcnt", {32'h0, rd_a}, 64'h0);
        chk("clr_wrcnt", {32'h0, wr_a}, 64'h0);
        tick_a();
        chk("clr_mem_kept", {32'h0, bus_a.r_data[2]}, 64'h0BADF00D);
        chk("clr_rdcnt1", {32'h0, rd_a}, 64'h1);

        // Reset while a response is showing drops it at once.
        idle_all();
        set_a(1, 1'b1, 14'h01C, 4'h0, 32'h0);
        tick_a();
        idle_all();
        rst_n = 1'b0;
        #1;
        chk("rst_drop_rvalid", {56'h0, bus_a.r_valid}, 64'h0);
        chk("rst_drop_rdata", {32'h0, bus_a.r_data[1]}, 64'h0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_a(2, 1'b1, 14'h01C, 4'h0, 32'h0);
        tick_a();
        chk("rst_mem_zero", {32'h0, bus_a.r_data[2]}, 64'h0);

        // Grant stall on dut_s: every third requesting cycle is denied.
        idle_all();
        nresp = 0;
        bus_s.req[0] = 1'b1;
        bus_s.wen[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            exp_g = ((k % 3) != 2);
            chk("stall_gnt", {63'h0, bus_s.gnt[0]}, {63'h0, exp_g});
            @(posedge clk); #1;
            chk("stall_rvalid", {63'h0, bus_s.r_valid[0]}, {63'h0, exp_g});
            if (bus_s.r_valid[0]) nresp++;
        end
        bus_s.req = '0;
        chk("stall_cnt", {32'h0, st_s}, 64'd2);
        chk("stall_rdcnt", {32'h0, rd_s}, 64'd4);
        chk("stall_nresp", 64'(nresp), 64'd4);

        // Saturation on the 4-bit counter of dut_c.
        bus_c.req[0] = 1'b1;
        bus_c.wen[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 14) chk("sat_rd14", {60'h0, rd_c}, 64'd14);
        end
        chk("sat_rd20", {60'h0, rd_c}, 64'd15);
        bus_c.req = '1;
        bus_c.wen = '1;
        @(posedge clk); #1;
        chk("sat_rd_burst", {60'h0, rd_c}, 64'd15);
        idle_all();
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
